iob2axil: RTL and testbench
===========================

Name: iob2axil

Overview:
- Bridges an IOb-bus slave port to an AXI4-Lite master port, the reverse of the AXIL-to-IOb peripheral adapter.
- Lets IOb-native masters (DMA engines, debug/boot controllers) reach AXI-Lite targets through the SoC interconnect.
- Single outstanding transaction, driven by a registered FSM, with sticky error reporting.

Parameters:
- ADDR_W, 32, address width of both the IOb and AXI-Lite sides.
- DATA_W, 32, data width; DATA_W/8 strobe bits.
- TIMEOUT_W, 16, width of the optional transaction watchdog counter.

Ports:
- clk_i  in  1  system clock
- arst_n_i  in  1  asynchronous reset, active-low
- cke_i  in  1  clock enable; all state holds when low
- iob_avalid_i  in  1  IOb request valid
- iob_addr_i  in  ADDR_W  byte address
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  write strobes; non-zero = write, zero = read
- iob_ready_o  out  1  bridge can accept a request
- iob_rvalid_o  out  1  read data valid, one-cycle pulse
- iob_rdata_o  out  DATA_W  read data
- axil_awaddr_o  out  ADDR_W  write address
- axil_awprot_o  out  3  fixed 3'b000
- axil_awvalid_o  out  1  AW valid
- axil_awready_i  in  1  AW ready
- axil_wdata_o  out  DATA_W  write data
- axil_wstrb_o  out  DATA_W/8  write strobes
- axil_wvalid_o  out  1  W valid
- axil_wready_i  in  1  W ready
- axil_bresp_i  in  2  write response
- axil_bvalid_i  in  1  B valid
- axil_bready_o  out  1  B ready
- axil_araddr_o  out  ADDR_W  read address
- axil_arprot_o  out  3  fixed 3'b000
- axil_arvalid_o  out  1  AR valid
- axil_arready_i  in  1  AR ready
- axil_rdata_i  in  DATA_W  read data
- axil_rresp_i  in  2  read response
- axil_rvalid_i  in  1  R valid
- axil_rready_o  out  1  R ready
- err_o  out  1  sticky: a non-OKAY response (or a timeout) occurred
- err_clr_i  in  1  clears err_o

Behaviour:
- Reset (arst_n_i low, asynchronous): FSM = IDLE; all AXI valids/readies = 0; iob_rvalid_o = 0; iob_rdata_o = 0; err_o = 0; latched addr/wdata/wstrb = 0.
- iob_ready_o = (state == IDLE), decoded from the registered state.
- Accept: avalid_i & ready_o. On accept, latch addr, wdata and wstrb, then go to WR_REQ (wstrb != 0) or RD_REQ.
- WR_REQ: awvalid_o and wvalid_o both high. Each drops independently on its own handshake, tracked by aw_done and w_done flags. When both are done, go to WR_RESP.
- WR_RESP: bready_o = 1. On bvalid, go to IDLE; if bresp != 2'b00, set err_o.
- RD_REQ: arvalid_o = 1. On arready, go to RD_RESP.
- RD_RESP: rready_o = 1. On rvalid:
  - register rdata into iob_rdata_o;
  - pulse iob_rvalid_o for exactly one cycle, in the next cycle;
  - go to IDLE;
  - if rresp != 2'b00, set err_o.
- No iob_rvalid_o for writes; a write completes when iob_ready_o returns high.
- Latency with zero-wait slaves (request accepted at cycle T):
  - read: arvalid at T+1, R handshake at T+2, iob_rvalid_o and iob_ready_o at T+3;
  - write: AW/W at T+1, B at T+2, iob_ready_o at T+3.
- AXI valids are held stable until their handshake and never depend on ready (no combinational ready-to-valid paths).
- iob_rdata_o holds its last value between reads.
- err_o:
  - err_clr_i has priority over a same-cycle error set; that error is lost. This is intentional and documented.
  - err_o stays high until cleared.
- cke_i low freezes the FSM, flags and outputs. Handshakes on AXI are not sampled while cke_i is low.
- Reset mid-transaction aborts immediately to IDLE. The downstream interconnect is also reset on the same reset.

Optional Feature:
- Macro: IOB2AXIL_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to any non-IDLE state and increments each enabled cycle outside IDLE.
  - At all-ones it forces the FSM to IDLE, deasserts all AXI valids/readies and sets err_o.
  - If the aborted transaction is a read, it pulses iob_rvalid_o with iob_rdata_o = 0.
  - This deliberately breaks AXI valid stability to unhang the debug path.
- Undefined: no counter logic; the bridge waits indefinitely.

Test Plan:
- Zero-wait read of 0x0000_0010 with slave rdata 0xCAFE_F00D, rresp OKAY -> iob_rvalid_o pulses at T+3 with rdata 0xCAFE_F00D; err_o stays 0.
- Write to 0x0000_0020, wdata 0x1234_5678, wstrb 4'b0011, with awready at T+1 and wready delayed to T+4 -> awvalid drops after T+1, wvalid held until T+4, W carries the exact data and strobes, iob_ready_o returns after B.
- Read with rresp 2'b10 -> data still returned; err_o = 1 and stays 1; err_clr_i pulse -> err_o = 0 the next cycle.
- Back-to-back: avalid_i held high with a read then a write -> second accepted only when iob_ready_o re-asserts; no overlap on AXI channels.
- arst_n_i low while in RD_RESP -> all outputs return to reset values asynchronously; no iob_rvalid_o pulse after release.
- With IOB2AXIL_TIMEOUT_EN and TIMEOUT_W=4, read where arready is never asserted -> after 15 cycles in RD_REQ: FSM goes to IDLE, iob_rvalid_o pulses with rdata 0, err_o = 1.

Source files
------------

// File: rtl/iob2axil_if.sv
// iob2axil_if: IOb request/response bus and AXI4-Lite bus bundles with master/slave views
interface iob_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              avalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output avalid, addr, wdata, wstrb, input ready, rvalid, rdata);
  modport slave (input avalid, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

interface axil_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/iob2axil.sv
// iob2axil: IOb slave to AXI4-Lite master bridge, one outstanding transaction; IOB2AXIL_TIMEOUT_EN adds a watchdog
module iob2axil #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 16
) (
  input  logic   clk_i,
  input  logic   arst_n_i,
  input  logic   cke_i,
  iob_if.slave   iob,
  axil_if.master axil,
  output logic   err_o,
  input  logic   err_clr_i
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
  state_t state, state_n;
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, to, rd_abort, err_set;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                rvalid_q;

  assign iob.ready     = state == IDLE;
  assign iob.rvalid    = rvalid_q;
  assign iob.rdata     = rdata_q;
  assign acc           = iob.avalid & iob.ready;
  // valids/readies come from registered state only; a watchdog abort drops them at once
  assign axil.awvalid  = state == WR_REQ & ~aw_done & ~to;
  assign axil.wvalid   = state == WR_REQ & ~w_done & ~to;
  assign axil.bready   = state == WR_RESP & ~to;
  assign axil.arvalid  = state == RD_REQ & ~to;
  assign axil.rready   = state == RD_RESP & ~to;
  assign axil.awaddr   = addr_q;
  assign axil.araddr   = addr_q;
  assign axil.wdata    = wdata_q;
  assign axil.wstrb    = wstrb_q;
  assign axil.awprot   = 3'b000;
  assign axil.arprot   = 3'b000;
  assign aw_hs         = axil.awvalid & axil.awready;
  assign w_hs          = axil.wvalid & axil.wready;
  assign b_hs          = axil.bvalid & axil.bready;
  assign ar_hs         = axil.arvalid & axil.arready;
  assign r_hs          = axil.rvalid & axil.rready;
  assign rd_abort      = to & (state == RD_REQ | state == RD_RESP);
  assign err_set       = (b_hs & |axil.bresp) | (r_hs & |axil.rresp) | to;

`ifdef IOB2AXIL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
  assign to = state != IDLE & &cnt;
  // watchdog restarts on every state change and counts enabled cycles while busy
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) cnt <= '0;
    else if (cke_i) cnt <= state_n != state ? '0 : state != IDLE ? cnt + 1'b1 : cnt;
`else
  assign to = 1'b0;
`endif

  // next state and AW/W completion flags; the W and AW channels finish independently
  always_comb begin
    state_n   = state;
    aw_done_n = aw_done | aw_hs;
    w_done_n  = w_done | w_hs;
    case (state)
      IDLE:    state_n = acc ? (|iob.wstrb ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  state_n = aw_done_n & w_done_n ? WR_RESP : WR_REQ;
      WR_RESP: state_n = b_hs ? IDLE : WR_RESP;
      RD_REQ:  state_n = ar_hs ? RD_RESP : RD_REQ;
      RD_RESP: state_n = r_hs ? IDLE : RD_RESP;
      default: state_n = IDLE;
    endcase
    if (to) state_n = IDLE;
    if (state_n != WR_REQ) begin
      aw_done_n = 1'b0;
      w_done_n  = 1'b0;
    end
  end

  // state register and completion flags
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (cke_i) begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
    end

  // request latch, read return and sticky error; a clear wins over a same-cycle error
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_o    <= 1'b0;
    end else if (cke_i) begin
      if (acc) begin
        addr_q  <= iob.addr;
        wdata_q <= iob.wdata;
        wstrb_q <= iob.wstrb;
      end
      if (r_hs | rd_abort) rdata_q <= rd_abort ? '0 : axil.rdata;
      rvalid_q <= r_hs | rd_abort;
      err_o    <= err_clr_i ? 1'b0 : err_o | err_set;
    end
endmodule

// File: tb/tb_iob2axil.sv
// tb_iob2axil: directed plus randomized checks of iob2axil against a word-memory reference model
module tb_iob2axil;
  logic clk_i = 1'b0, arst_n_i = 1'b0, cke_i = 1'b1, err_clr_i = 1'b0;
  logic err_o;
  int tests = 0, fails = 0;
  logic err_exp = 1'b0;
  logic [31:0] rd_exp = '0;
  logic [31:0] smem [8];
  logic [31:0] mmem [8];
  logic hold = 1'b0;
  logic [31:0] nx_addr, nx_wdata;
  logic [3:0] nx_wstrb;

  iob_if #(.ADDR_W(32), .DATA_W(32)) iob ();
  axil_if #(.ADDR_W(32), .DATA_W(32)) axil ();

  iob2axil #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(16)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .iob(iob), .axil(axil),
    .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk_ch(input string tag, input logic aw, input logic w, input logic b, input logic ar, input logic r);
    chk({tag, ".awvalid"}, 32'(axil.awvalid), 32'(aw));
    chk({tag, ".wvalid"}, 32'(axil.wvalid), 32'(w));
    chk({tag, ".bready"}, 32'(axil.bready), 32'(b));
    chk({tag, ".arvalid"}, 32'(axil.arvalid), 32'(ar));
    chk({tag, ".rready"}, 32'(axil.rready), 32'(r));
    chk({tag, ".prot"}, 32'({axil.awprot, axil.arprot}), 32'd0);
  endtask

  task automatic merge(inout logic [31:0] word, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iob.avalid = 1'b1;
    iob.addr = a;
    iob.wdata = d;
    iob.wstrb = s;
    chk("accept.ready", 32'(iob.ready), 32'd1);
    step;
    if (hold) begin
      iob.addr = nx_addr;
      iob.wdata = nx_wdata;
      iob.wstrb = nx_wstrb;
      hold = 1'b0;
    end else begin
      iob.avalid = 1'b0;
      iob.addr = $urandom;
      iob.wdata = $urandom;
      iob.wstrb = 4'($urandom);
    end
  endtask

  task automatic idle(input logic clr);
    err_clr_i = clr;
    step;
    err_clr_i = 1'b0;
    if (clr) err_exp = 1'b0;
    chk("idle.ready", 32'(iob.ready), 32'd1);
    chk("idle.rvalid", 32'(iob.rvalid), 32'd0);
    chk("idle.rdata", iob.rdata, rd_exp);
    chk("idle.err", 32'(err_o), 32'(err_exp));
    chk_ch("idle", 0, 0, 0, 0, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] rr, input int ard, input int rd,
                         input logic clr, input logic ckeg);
    logic [2:0] sidx;
    sidx = '0;
    accept(a, 32'd0, 4'd0);
    for (int i = 0; i <= ard; i++) begin
      chk_ch("rd_ar", 0, 0, 0, 1, 0);
      chk("rd_ar.araddr", axil.araddr, a);
      chk("rd_ar.ready", 32'(iob.ready), 32'd0);
      chk("rd_ar.rvalid", 32'(iob.rvalid), 32'd0);
      chk("rd_ar.rdata_hold", iob.rdata, rd_exp);
      if (i == ard) begin
        axil.arready = 1'b1;
        sidx = axil.araddr[4:2];
        if (ckeg) begin
          cke_i = 1'b0;
          repeat (2) begin
            step;
            chk_ch("cke_hold", 0, 0, 0, 1, 0);
          end
          cke_i = 1'b1;
        end
      end
      step;
      axil.arready = 1'b0;
    end
    for (int i = 0; i <= rd; i++) begin
      chk_ch("rd_r", 0, 0, 0, 0, 1);
      chk("rd_r.ready", 32'(iob.ready), 32'd0);
      chk("rd_r.rvalid", 32'(iob.rvalid), 32'd0);
      axil.rvalid = i == rd;
      axil.rdata = i == rd ? smem[sidx] : $urandom;
      axil.rresp = i == rd ? rr : 2'($urandom);
      err_clr_i = i == rd ? clr : 1'b0;
      step;
    end
    axil.rvalid = 1'b0;
    err_clr_i = 1'b0;
    rd_exp = mmem[a[4:2]];
    err_exp = clr ? 1'b0 : err_exp | (rr != 2'b00);
    chk("rd.rvalid", 32'(iob.rvalid), 32'd1);
    chk("rd.rdata", iob.rdata, rd_exp);
    chk("rd.ready", 32'(iob.ready), 32'd1);
    chk("rd.err", 32'(err_o), 32'(err_exp));
    chk_ch("rd_done", 0, 0, 0, 0, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] br,
                          input int awd, input int wd, input int bd, input logic clr);
    logic awdn, wdn;
    logic [31:0] saddr, swd;
    logic [3:0] sws;
    int n;
    awdn = 1'b0;
    wdn = 1'b0;
    saddr = '0;
    swd = '0;
    sws = '0;
    n = awd > wd ? awd : wd;
    accept(a, d, s);
    for (int i = 0; i <= n; i++) begin
      chk_ch("wr_req", !awdn, !wdn, 0, 0, 0);
      if (!awdn) chk("wr.awaddr", axil.awaddr, a);
      if (!wdn) chk("wr.wdata", axil.wdata, d);
      if (!wdn) chk("wr.wstrb", 32'(axil.wstrb), 32'(s));
      chk("wr_req.ready", 32'(iob.ready), 32'd0);
      chk("wr_req.rvalid", 32'(iob.rvalid), 32'd0);
      chk("wr_req.rdata_hold", iob.rdata, rd_exp);
      axil.awready = i == awd;
      axil.wready = i == wd;
      if (i == awd) saddr = axil.awaddr;
      if (i == wd) begin
        swd = axil.wdata;
        sws = axil.wstrb;
      end
      step;
      if (i == awd) awdn = 1'b1;
      if (i == wd) wdn = 1'b1;
    end
    axil.awready = 1'b0;
    axil.wready = 1'b0;
    merge(smem[saddr[4:2]], swd, sws);
    merge(mmem[a[4:2]], d, s);
    for (int i = 0; i <= bd; i++) begin
      chk_ch("wr_b", 0, 0, 1, 0, 0);
      chk("wr_b.ready", 32'(iob.ready), 32'd0);
      axil.bvalid = i == bd;
      axil.bresp = i == bd ? br : 2'($urandom);
      err_clr_i = i == bd ? clr : 1'b0;
      step;
    end
    axil.bvalid = 1'b0;
    err_clr_i = 1'b0;
    err_exp = clr ? 1'b0 : err_exp | (br != 2'b00);
    chk("wr.ready", 32'(iob.ready), 32'd1);
    chk("wr.rvalid", 32'(iob.rvalid), 32'd0);
    chk("wr.err", 32'(err_o), 32'(err_exp));
    chk_ch("wr_done", 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0] rsp;
    iob.avalid = 1'b0; iob.addr = '0; iob.wdata = '0; iob.wstrb = '0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = '0;
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = '0; axil.rresp = '0;
    for (int i = 0; i < 8; i++) begin
      smem[i] = '0;
      mmem[i] = '0;
    end
    smem[4] = 32'hCAFE_F00D;
    mmem[4] = 32'hCAFE_F00D;
    nx_addr = '0; nx_wdata = '0; nx_wstrb = '0;

    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    step;
    chk("rst.ready", 32'(iob.ready), 32'd1);
    chk("rst.rvalid", 32'(iob.rvalid), 32'd0);
    chk("rst.rdata", iob.rdata, 32'd0);
    chk("rst.err", 32'(err_o), 32'd0);
    chk("rst.awaddr", axil.awaddr, 32'd0);
    chk("rst.wstrb", 32'(axil.wstrb), 32'd0);
    chk_ch("rst", 0, 0, 0, 0, 0);

    do_read(32'h10, 2'b00, 0, 0, 1'b0, 1'b0);
    do_write(32'h20, 32'h1234_5678, 4'b0011, 2'b00, 0, 3, 0, 1'b0);
    do_read(32'h20, 2'b10, 1, 1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    do_read(32'h10, 2'b11, 0, 0, 1'b1, 1'b0);

    nx_addr = 32'h4; nx_wdata = 32'hA5A5_A5A5; nx_wstrb = 4'b1111;
    hold = 1'b1;
    do_read(32'h20, 2'b00, 2, 1, 1'b0, 1'b1);
    do_write(nx_addr, nx_wdata, nx_wstrb, 2'b00, 1, 0, 2, 1'b0);
    do_write(32'h8, 32'hDEAD_BEEF, 4'b1000, 2'b11, 0, 0, 0, 1'b0);

    accept(32'h10, 32'd0, 4'd0);
    axil.arready = 1'b1;
    step;
    axil.arready = 1'b0;
    chk_ch("pre_rst", 0, 0, 0, 0, 1);
    axil.rvalid = 1'b1;
    axil.rdata = 32'h5555_AAAA;
    #2 arst_n_i = 1'b0;
    #1;
    err_exp = 1'b0;
    rd_exp = '0;
    chk("arst.ready", 32'(iob.ready), 32'd1);
    chk("arst.rvalid", 32'(iob.rvalid), 32'd0);
    chk("arst.rdata", iob.rdata, 32'd0);
    chk("arst.err", 32'(err_o), 32'd0);
    chk_ch("arst", 0, 0, 0, 0, 0);
    axil.rvalid = 1'b0;
    @(negedge clk_i);
    step;
    arst_n_i = 1'b1;
    idle(1'b0);
    idle(1'b0);

    for (int k = 0; k < 40; k++) begin
      a = {27'd0, 3'($urandom), 2'b00};
      rsp = $urandom_range(0, 3) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        do_read(a, rsp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0);
      else
        do_write(a, $urandom, 4'($urandom_range(1, 15)), rsp, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3) == 0);
    end
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
